// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// requester indices and the read-latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    // Wide enough to count up to the largest supported read latency (15).
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin selector. On a tie, the requester that
// was not served last wins. The output is a one-hot grant, or 00 with no request.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // last_i = 1 means the debug requester was served last, so the CPU wins a tie.
    always_comb begin
        grant_o          = 2'b00;
        grant_o[REQ_CPU] = req_i[REQ_CPU] & (~req_i[REQ_DBG] | last_i);
        grant_o[REQ_DBG] = req_i[REQ_DBG] & (~req_i[REQ_CPU] | ~last_i);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a processor and a loader/debug port onto one memory unit.
// Each transaction runs IDLE -> ACCESS -> DONE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iData0,
    input  logic [DATA_W-1:0] iData1,
    input  logic              iRead0,
    input  logic              iRead1,
    input  logic              iWrite0,
    input  logic              iWrite1,
    output logic [DATA_W-1:0] oData0,
    output logic [DATA_W-1:0] oData1,
    output logic              oRdy0,
    output logic              oRdy1,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemData,
    output logic              oMemRead,
    output logic              oMemWrite,
    input  logic [DATA_W-1:0] iMemData,
    output logic [1:0]        oGrant
);

    localparam logic [LAT_CNT_W-1:0] LAST_BEAT = LAT_CNT_W'(RD_LAT - 1);

    arb_state_e            state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_q, last_d;
    logic                  just_done_q, just_done_d;
    logic                  is_write_q, is_write_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]     data0_q, data0_d;
    logic [DATA_W-1:0]     data1_q, data1_d;

    logic [1:0]            req_mask;
    logic [1:0]            req_vec;
    logic [1:0]            pick_grant;

    // In the IDLE cycle right after DONE, the owner is still holding its
    // strobe; mask it so that strobe is not taken as a new request.
    always_comb begin
        req_mask = 2'b11;
        if (just_done_q) begin
            req_mask = last_q ? 2'b01 : 2'b10;
        end
        req_vec = {iRead1 | iWrite1, iRead0 | iWrite0} & req_mask;
    end

    rr_pick u_rr_pick (
        .req_i   (req_vec),
        .last_i  (last_q),
        .grant_o (pick_grant)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        just_done_d = 1'b0;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        data0_d     = data0_q;
        data1_d     = data1_q;

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    grant_d = pick_grant;
                    last_d  = pick_grant[REQ_DBG];
                    cnt_d   = '0;
                    state_d = ACCESS;
                    if (pick_grant[REQ_DBG]) begin
                        addr_d     = iAddr1;
                        wdata_d    = iData1;
                        is_write_d = iWrite1;
                    end else begin
                        addr_d     = iAddr0;
                        wdata_d    = iData0;
                        is_write_d = iWrite0;
                    end
                end
            end
            ACCESS: begin
                if (is_write_q) begin
                    state_d = DONE;
                end else if (cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                    if (grant_q[REQ_DBG]) begin
                        data1_d = iMemData;
                    end else begin
                        data0_d = iMemData;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                grant_d     = 2'b00;
                just_done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Reset clears everything; last_q starts at 1 so the CPU wins the first tie.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            just_done_q <= 1'b0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            just_done_q <= just_done_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
        end
    end

    assign oMemRead  = (state_q == ACCESS) && !is_write_q;
    assign oMemWrite = (state_q == ACCESS) && is_write_q;
    assign oMemAddr  = addr_q;
    assign oMemData  = wdata_q;
    assign oRdy0     = (state_q == DONE) && grant_q[REQ_CPU];
    assign oRdy1     = (state_q == DONE) && grant_q[REQ_DBG];
    assign oGrant    = grant_q;
    assign oData0    = data0_q;
    assign oData1    = data1_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 SHALL have parameter RD_LAT, default 2, range 1-15, meaning the number of cycles oMemRead is held per read.
REQ-004 SHALL have port iClk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port iRst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports iAddr0/iAddr1  input  ADDR_W  requester 0 (processor) and requester 1 (loader/debug) address.
REQ-007 SHALL have ports iData0/iData1  input  DATA_W  requester write data.
REQ-008 SHALL have ports iRead0/iRead1 and iWrite0/iWrite1  input  1  requester read and write strobes, held until oRdyN.
REQ-009 SHALL have ports oData0/oData1  output  DATA_W  read data returned to each requester.
REQ-010 SHALL have ports oRdy0/oRdy1  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports oMemAddr  output  ADDR_W, oMemData  output  DATA_W, oMemRead  output  1, oMemWrite  output  1, forming the shared memory-unit request.
REQ-012 SHALL have port iMemData  input  DATA_W  memory-unit read data.
REQ-013 SHALL have port oGrant  output  2  one-hot owner of the current transaction; 00 when idle.

Function
REQ-014 SHALL implement the states IDLE, ACCESS and DONE.
REQ-015 SHALL, in IDLE with any request asserted, select an owner, latch that owner's address, data and operation, and enter ACCESS on the next edge.
REQ-016 SHALL grant a lone requester immediately.
REQ-017 SHALL, when both requesters ask in the same IDLE cycle, grant the requester not served last (round-robin).
REQ-018 SHALL treat a requester asserting iRead and iWrite together as a write.
REQ-019 SHALL, for a write, drive oMemWrite=1 with the latched address and data for exactly 1 ACCESS cycle and then enter DONE.
REQ-020 SHALL, for a read, drive oMemRead=1 with the latched address for exactly RD_LAT ACCESS cycles, capture iMemData at the edge ending the last of those cycles, and then enter DONE.
REQ-021 SHALL keep oMemRead and oMemWrite at 0 outside ACCESS, and SHALL hold oMemAddr and oMemData at the latched values while in ACCESS.
REQ-022 SHALL assert oRdyN for exactly the 1 DONE cycle of the owner, then return to IDLE.
REQ-023 SHALL, for a read, present the captured word on oDataN in the DONE cycle and hold it until that requester's next read completes.
REQ-024 SHALL give a latency, counted from the request being sampled in IDLE to oRdy, of 2 cycles for a write and RD_LAT+1 cycles for a read.
REQ-025 SHALL ignore the requester in the IDLE cycle immediately after its DONE; the requester deasserts on seeing oRdy, and a still-held strobe in that cycle is not a new request.
REQ-026 SHALL accept a new request in IDLE only, so back-to-back transactions from one requester are spaced by at least 1 IDLE cycle.
REQ-027 SHALL allow the other requester to win in the IDLE cycle following DONE, giving no bubble beyond IDLE.
REQ-028 SHALL NOT change the latched transaction in response to requests changing during ACCESS or DONE.
REQ-029 SHALL hold oGrant one-hot from ACCESS through DONE.

Reset
REQ-030 SHALL, on iRst=1, go immediately to IDLE with oMemRead=0, oMemWrite=0, oMemAddr=0, oMemData=0, oRdy0=0, oRdy1=0, oData0=0, oData1=0 and oGrant=00.
REQ-031 SHALL, on reset mid-transaction, drop the transaction with no oRdy pulse.
REQ-032 SHALL reset the round-robin pointer to "last served = 1", so requester 0 wins the first tie.

Structure
REQ-033 SHALL place the state enum, the requester index constants (REQ_CPU=0, REQ_DBG=1) and the RD_LAT counter width in shared package mem_arb_pkg.
REQ-034 SHALL use one sub-module, rr_pick: a combinational 2-way round-robin selector taking the request vector and the last-served index and returning a one-hot grant.
REQ-035 SHALL keep the read-latency counter and the data capture in mem_arbiter.

Verification
REQ-036 SHALL cover a lone read: RD_LAT=2, iRead0 at addr 0x10, memory returns 0xDEADBEEF -> oMemRead high 2 cycles, oRdy0 at cycle 3, oData0=0xDEADBEEF, oGrant=01.
REQ-037 SHALL cover a lone write: iWrite1, addr 0x20, data 0x1234 -> oMemWrite high 1 cycle with 0x20/0x1234, oRdy1 at cycle 2.
REQ-038 SHALL cover a tie after reset: both read in the same cycle -> requester 0 served first, requester 1 served in the IDLE cycle after oRdy0, and the next tie goes to requester 0 again.
REQ-039 SHALL cover simultaneous iRead0 and iWrite0 -> a write is issued (oMemWrite=1, oMemRead=0).
REQ-040 SHALL cover iRst pulsed during read ACCESS -> all outputs 0 within the reset cycle, no oRdy, and a fresh request afterwards completes normally.
REQ-041 SHALL cover iRead0 held through DONE and one more cycle -> only one transaction is issued.
